// File: rtl/emailbox.sv
// emailbox: mailbox FIFO fed by emesh write packets addressed to this chip's mailbox offset.
// Provides a show-ahead head entry, occupancy flags, a threshold interrupt and sticky overflow.
module emailbox #(
  parameter int          AW        = 32,
  parameter int          PW        = 2*AW+40,
  parameter int          DEPTH     = 16,
  parameter logic [11:0] ID        = 12'h800,
  parameter logic [19:0] MBOX_ADDR = 20'hF0320
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       wr_access,
  input  logic [PW-1:0]              wr_packet,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH):0]     irq_thresh,
  input  logic                       irq_en,
  input  logic                       ovf_clr,
  output logic [2*AW-1:0]            rd_data,
  output logic                       mailbox_not_empty,
  output logic                       mailbox_full,
  output logic                       mailbox_irq,
  output logic                       mailbox_ovf,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTW = $clog2(DEPTH);
  localparam int CW  = PTW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [2*AW-1:0] mem [DEPTH];
  logic [PTW-1:0]  wr_ptr, rd_ptr;
  logic [AW-1:0]   dstaddr;
  logic            push_req, push, pop;
  assign dstaddr  = wr_packet[AW+6:7];
  assign push_req = wr_access && wr_packet[0] && dstaddr[AW-1:AW-12] == ID && dstaddr[19:0] == MBOX_ADDR;
  assign pop      = rd_en && count != '0;
  // a full box still accepts a push when the head leaves in the same cycle
  assign push     = push_req && (!mailbox_full || pop);
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mailbox_ovf <= 1'b0;
    end else begin
      wr_ptr      <= push ? wr_ptr + PTW'(1) : wr_ptr;
      rd_ptr      <= pop ? rd_ptr + PTW'(1) : rd_ptr;
      count       <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
      mailbox_ovf <= (push_req && !push) ? 1'b1 : ovf_clr ? 1'b0 : mailbox_ovf;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {wr_packet[3*AW+6:2*AW+7], wr_packet[2*AW+6:AW+7]};
  assign rd_data           = mem[rd_ptr];
  assign mailbox_not_empty = count != '0;
  assign mailbox_full      = count == FULL_CNT;
  assign mailbox_irq       = irq_en && count >= irq_thresh && irq_thresh != '0;
endmodule

// File: doc/emailbox.md
EMAILBOX -- requirements
Module: emailbox

Interface
REQ-001 SHALL have parameter AW, default 32: address/data width.
REQ-002 SHALL have parameter PW, default 2*AW+40: packet width (104 at AW=32).
REQ-003 SHALL have parameter DEPTH, default 16: entry count; power of 2, >=2.
REQ-004 SHALL have parameter ID, default 12'h800: chip ID matched against dstaddr[AW-1:AW-12].
REQ-005 SHALL have parameter MBOX_ADDR, default 20'hF0320: mailbox offset matched against dstaddr[19:0].
REQ-006 SHALL have port clk, input, 1: the only clock; all state on its rising edge.
REQ-007 SHALL have port nreset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port wr_access, input, 1: packet valid strobe.
REQ-009 SHALL have port wr_packet, input, PW: emesh packet; [0] write, [2:1] datamode, [6:3] ctrlmode, [AW+6:7] dstaddr, [2*AW+6:AW+7] data, [3*AW+6:2*AW+7] srcaddr.
REQ-010 SHALL have port rd_en, input, 1: pop head entry.
REQ-011 SHALL have port irq_thresh, input, $clog2(DEPTH)+1: interrupt level.
REQ-012 SHALL have port irq_en, input, 1: interrupt enable.
REQ-013 SHALL have port ovf_clr, input, 1: clear sticky overflow.
REQ-014 SHALL have port rd_data, output, 2*AW: head entry {srcaddr,data}; show-ahead.
REQ-015 SHALL have port mailbox_not_empty, output, 1: count != 0.
REQ-016 SHALL have port mailbox_full, output, 1: count == DEPTH.
REQ-017 SHALL have port mailbox_irq, output, 1: irq_en && count >= irq_thresh && irq_thresh != 0.
REQ-018 SHALL have port mailbox_ovf, output, 1: sticky; a push was dropped.
REQ-019 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy.

Function
REQ-020 Push request SHALL be wr_access && wr_packet[0] && ID match && MBOX_ADDR match; reads and non-matching packets are ignored without side effects.
REQ-021 Storage SHALL be a DEPTH-entry circular buffer with $clog2(DEPTH)-bit write/read pointers that wrap from DEPTH-1 to 0.
REQ-022 Pop SHALL be accepted only when rd_en && count != 0; rd_en when empty is ignored.
REQ-023 Push SHALL be accepted when count < DEPTH, or when count == DEPTH and a pop is accepted in the same cycle.
REQ-024 A push request not accepted SHALL be dropped and SHALL set mailbox_ovf on the next edge.
REQ-025 count SHALL be +1 on push-only, -1 on pop-only, and unchanged on simultaneous push+pop or on neither.
REQ-026 Latency SHALL be 1 cycle: a push at edge N makes count, flags and rd_data (if it becomes head) valid after edge N.
REQ-027 After an accepted pop at edge N, rd_data SHALL present the next entry after edge N.
REQ-028 A push into an empty box with a simultaneous ignored pop SHALL leave the entry intact.
REQ-029 mailbox_full, mailbox_not_empty and mailbox_irq SHALL be decoded from registered count and SHALL be glitch-free.
REQ-030 ovf_clr SHALL clear mailbox_ovf; set and clear in the same cycle SHALL resolve as set.
REQ-031 rd_data SHALL be don't-care when empty; the bench SHALL NOT check it then.

Reset
REQ-032 nreset low SHALL asynchronously clear pointers, count and mailbox_ovf; mailbox_not_empty=0, mailbox_full=0, mailbox_irq=0.
REQ-033 Entry storage SHALL NOT be reset.
REQ-034 Reset asserted mid-operation SHALL discard all entries; the first push after release SHALL land at index 0.
REQ-035 Release SHALL be synchronous to clk externally; this block adds no synchronizer.

Verification
REQ-036 Push 3 packets (data 0x11,0x22,0x33; srcaddr 0x80000000) -> count=3, rd_data={0x80000000,0x11}; 3 pops -> 0x22, 0x33, then not_empty=0.
REQ-037 DEPTH=16: 16 pushes -> full=1; 17th push -> dropped, ovf=1, count=16; ovf_clr -> ovf=0.
REQ-038 Full box with simultaneous push and pop -> count stays 16, head advances, new entry at tail, ovf=0.
REQ-039 irq_thresh=4, irq_en=1: push 3 -> irq=0; push 4th -> irq=1; pop 1 -> irq=0; irq_en=0 with count 4 -> irq=0.
REQ-040 Packets with dstaddr ID 0x810, with wrong offset, or with write=0 -> count unchanged, ovf=0.
REQ-041 Wrap test: 40 push/pop pairs with incrementing data -> FIFO order preserved across wrap; nreset pulse with count=5 -> count=0, flags 0, next push reads back at head.
